// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
//
// Shared definitions for the MLP layer sequencer:
//   - state_t       : layer sequencer FSM states (IDLE .. DONE)
//   - DEF_N_IN      : default accumulation length (inputs per neuron)
//   - DEF_N_NEURON  : default neurons per layer
//   - DEF_N_PU      : default number of parallel processing units
//   - clog2_min1()  : ceiling log2 clamped to at least 1, used to size the
//                     address / group counters so a single-entry range still
//                     gets a real 1-bit port.
// -----------------------------------------------------------------------------
package mlp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DEF_N_IN     = 64;
  localparam int DEF_N_NEURON = 8;
  localparam int DEF_N_PU     = 4;

  // Number of bits needed to count 0..value-1, never less than 1.
  function automatic int clog2_min1(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/mlp_idx_counter.sv
// -----------------------------------------------------------------------------
// mlp_idx_counter
//
// Saturating up-counter used for the input address and the neuron group index.
// It counts 0..LAST and then holds at LAST; it never wraps on its own, only a
// clear (or reset) brings it back to 0. Clear has priority over increment.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset, forces count to 0
//   clr      in   synchronous clear to 0
//   inc      in   advance by one (ignored once the count reached LAST)
//   count    out  WIDTH  current count (registered)
//   is_last  out  1      count equals LAST
// -----------------------------------------------------------------------------
module mlp_idx_counter #(
  parameter int WIDTH = 1,
  parameter int LAST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             is_last
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (inc && (count_reg != LAST_V)) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count   = count_reg;
  assign is_last = (count_reg == LAST_V);

endmodule

// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Walks one MLP layer: for each group of N_PU neurons it clears the PU
// accumulators, then for every input index issues one start pulse to the PU
// array and waits for its ready, then loads the group's results into the
// activation buffer. After the last group a one-cycle done pulse is produced.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   begin a layer (only looked at in IDLE)
//   pu_ready  in   PU array finished the current MAC step (only looked at in WAIT)
//   pu_start  out  one-cycle start to all PUs
//   pu_clr    out  one-cycle accumulator clear
//   in_addr   out  IN_AW  input / weight-column address, stable ISSUE..WAIT
//   grp_idx   out  GRP_W  current neuron group (weight-row base = grp_idx*N_PU)
//   act_ld    out  one-cycle load of the group's PU results
//   busy      out  high in every state except IDLE
//   done      out  one-cycle pulse, layer complete
//
// All strobes are decoded from the state register only, so they are glitch-free
// with respect to start / pu_ready and never combinationally loop back into
// the PU array.
// -----------------------------------------------------------------------------
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int N_IN     = DEF_N_IN,
  parameter int N_NEURON = DEF_N_NEURON,
  parameter int N_PU     = DEF_N_PU,
  parameter int IN_AW    = clog2_min1(N_IN),
  parameter int GRP_W    = clog2_min1(N_NEURON / N_PU)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pu_ready,
  output logic             pu_start,
  output logic             pu_clr,
  output logic [IN_AW-1:0] in_addr,
  output logic [GRP_W-1:0] grp_idx,
  output logic             act_ld,
  output logic             busy,
  output logic             done
);

  localparam int N_GRP = N_NEURON / N_PU;

  state_t state_reg;
  state_t state_next;

  logic in_clr;
  logic in_inc;
  logic in_last;
  logic grp_clr;
  logic grp_inc;
  logic grp_last;

  // ---------------------------------------------------------------------------
  // Counters. Both saturate at their last value, so after a layer they keep
  // showing the final address / group until the next start clears them.
  // ---------------------------------------------------------------------------
  mlp_idx_counter #(
    .WIDTH (IN_AW),
    .LAST  (N_IN - 1)
  ) u_in_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (in_clr),
    .inc     (in_inc),
    .count   (in_addr),
    .is_last (in_last)
  );

  mlp_idx_counter #(
    .WIDTH (GRP_W),
    .LAST  (N_GRP - 1)
  ) u_grp_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (grp_clr),
    .inc     (grp_inc),
    .count   (grp_idx),
    .is_last (grp_last)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state, counter controls and state-decoded strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    pu_clr     = 1'b0;
    pu_start   = 1'b0;
    act_ld     = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    in_clr     = 1'b0;
    in_inc     = 1'b0;
    grp_clr    = 1'b0;
    grp_inc    = 1'b0;

    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          in_clr     = 1'b1;
          grp_clr    = 1'b1;
          state_next = CLR;
        end
      end

      CLR: begin
        pu_clr     = 1'b1;
        state_next = ISSUE;
      end

      ISSUE: begin
        pu_start   = 1'b1;
        state_next = WAIT;
      end

      // in_addr only moves on the ready edge, so the PUs see a stable address
      // for the whole ISSUE..WAIT window of each MAC step.
      WAIT: begin
        if (pu_ready) begin
          if (in_last) begin
            state_next = STORE;
          end else begin
            in_inc     = 1'b1;
            state_next = ISSUE;
          end
        end
      end

      STORE: begin
        act_ld = 1'b1;
        if (grp_last) begin
          state_next = DONE;
        end else begin
          grp_inc    = 1'b1;
          in_clr     = 1'b1;
          state_next = CLR;
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
